// File: rtl/router_pkt_fifo_pkg.sv
// Shared defaults and header-field helper for the router output FIFOs.
// No logic; imported by the FIFO top and its storage array.
package router_pkt_fifo_pkg;

  localparam int ROUTER_DATA_WIDTH = 8;
  localparam int ROUTER_FIFO_DEPTH = 16;
  localparam int ROUTER_LEN_MSB    = 7;
  localparam int ROUTER_LEN_LSB    = 2;

  // Payload-length field of a header word, right-aligned.
  function automatic logic [31:0] hdr_len(input logic [63:0] word, input int msb, input int lsb);
    logic [63:0] mask;
    mask = (64'd1 << (msb - lsb + 1)) - 64'd1;
    return 32'((word >> lsb) & mask);
  endfunction

endpackage

// File: rtl/router_pkt_fifo_mem.sv
// Storage array for the packet FIFO: one write port, one asynchronous read port.
// Write lands on the clock edge; read data follows rd_addr combinationally.
// No flow control here; the caller gates wr_en.
module router_pkt_fifo_mem #(
  parameter  int WIDTH = 9,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_dat
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_dat;
  end

  assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/router_pkt_fifo.sv
// Packet-aware output FIFO for one router destination channel, tagging header words.
// Read latency 1 cycle (registered data_out); written word readable the cycle after the write.
// Writes at full are dropped, reads at empty ignored; soft_reset flushes everything.
module router_pkt_fifo
  import router_pkt_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = ROUTER_DATA_WIDTH,
  parameter int DEPTH      = ROUTER_FIFO_DEPTH,
  parameter int LEN_MSB    = ROUTER_LEN_MSB,
  parameter int LEN_LSB    = ROUTER_LEN_LSB,
  parameter int AF_THRESH  = DEPTH - 2,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  soft_reset,
  input  logic                  write_enb,
  input  logic                  read_enb,
  input  logic                  lfd_state,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_W:0]       fill_level,
  output logic [ADDR_W:0]       pkts_stored,
  output logic                  pkt_done
);

  localparam int REM_W = LEN_MSB - LEN_LSB + 2;
  localparam logic [ADDR_W:0]  CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]  CNT_ZERO = '0;
  localparam logic [ADDR_W:0]  AF_LVL   = (ADDR_W+1)'(AF_THRESH);
  localparam logic [REM_W-1:0] REM_ONE  = REM_W'(1);

  logic [ADDR_W:0]     wptr, rptr;
  logic                lfd_d;
  logic [REM_W-1:0]    remain;
  logic [DATA_WIDTH:0] rd_word;
  logic                wr_acc, rd_acc, rd_tag, wr_tag;

  assign empty  = (wptr == rptr);
  assign full   = (wptr[ADDR_W] != rptr[ADDR_W]) &&
                  (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);
  assign wr_acc = write_enb && !full  && !soft_reset;
  assign rd_acc = read_enb  && !empty && !soft_reset;
  assign rd_tag = rd_word[DATA_WIDTH];
  assign wr_tag = wr_acc && lfd_d;

  assign almost_full = (fill_level >= AF_LVL);

  router_pkt_fifo_mem #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_mem (
    .clock   (clock),
    .wr_en   (wr_acc),
    .wr_addr (wptr[ADDR_W-1:0]),
    .wr_dat  ({lfd_d, data_in}),
    .rd_addr (rptr[ADDR_W-1:0]),
    .rd_dat  (rd_word)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr        <= '0;
      rptr        <= '0;
      lfd_d       <= 1'b0;
      fill_level  <= '0;
      pkts_stored <= '0;
      remain      <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      pkt_done    <= 1'b0;
    end else if (soft_reset) begin
      wptr        <= '0;
      rptr        <= '0;
      lfd_d       <= 1'b0;
      fill_level  <= '0;
      pkts_stored <= '0;
      remain      <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      pkt_done    <= 1'b0;
    end else begin
      lfd_d       <= lfd_state;
      if (wr_acc) wptr <= wptr + CNT_ONE;
      if (rd_acc) rptr <= rptr + CNT_ONE;
      fill_level  <= fill_level  + (wr_acc ? CNT_ONE : CNT_ZERO)
                                 - (rd_acc ? CNT_ONE : CNT_ZERO);
      pkts_stored <= pkts_stored + (wr_tag ? CNT_ONE : CNT_ZERO)
                                 - ((rd_acc && rd_tag) ? CNT_ONE : CNT_ZERO);
      data_valid  <= rd_acc;
      pkt_done    <= rd_acc && !rd_tag && (remain == REM_ONE);

      // Idle output returns to zero only between packets.
      if (rd_acc)
        data_out <= rd_word[DATA_WIDTH-1:0];
      else if (remain == '0)
        data_out <= '0;

      // A new header restarts the count even if the old packet was cut short.
      if (rd_acc && rd_tag)
        remain <= REM_W'(hdr_len(64'(rd_word[DATA_WIDTH-1:0]), LEN_MSB, LEN_LSB)) + REM_ONE;
      else if (rd_acc && remain != '0)
        remain <= remain - REM_ONE;
    end
  end

endmodule

// File: tb/tb_router_pkt_fifo.sv
// Randomised and directed bench for router_pkt_fifo against a queue-based packet model.
module tb_router_pkt_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AF    = DEPTH - 2;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          soft_reset = 1'b0;
  logic          write_enb = 1'b0;
  logic          read_enb = 1'b0;
  logic          lfd_state = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic          data_valid, empty, full, almost_full, pkt_done;
  logic [4:0]    fill_level, pkts_stored;

  router_pkt_fifo dut (
    .clock       (clock),
    .reset       (reset),
    .soft_reset  (soft_reset),
    .write_enb   (write_enb),
    .read_enb    (read_enb),
    .lfd_state   (lfd_state),
    .data_in     (data_in),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .fill_level  (fill_level),
    .pkts_stored (pkts_stored),
    .pkt_done    (pkt_done)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  // Reference model: queue of {tag, data}, plus bytes-left-in-packet counter.
  logic [DW:0]   q[$];
  bit            m_lfd;
  int            m_rem;
  logic [DW-1:0] m_dout;
  bit            m_dv, m_done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_pkts();
    int n = 0;
    foreach (q[i]) if (q[i][DW]) n++;
    return n;
  endfunction

  task automatic model_clear();
    q.delete();
    m_lfd = 0; m_rem = 0; m_dout = '0; m_dv = 0; m_done = 0;
  endtask

  task automatic model_step(input bit w, input bit r, input bit l, input bit s, input logic [DW-1:0] d);
    bit            rd, wr;
    logic [DW:0]   word;
    int            old_rem;
    if (s) begin
      model_clear();
      return;
    end
    rd = r && (q.size() != 0);
    wr = w && (q.size() != DEPTH);
    word = '0;
    if (rd) word = q.pop_front();
    if (wr) q.push_back({m_lfd, d});
    old_rem = m_rem;
    m_done = 0;
    if (rd) begin
      if (word[DW]) m_rem = int'(word[7:2]) + 1;
      else if (m_rem > 0) begin
        if (m_rem == 1) m_done = 1;
        m_rem--;
      end
      m_dout = word[DW-1:0];
    end else if (old_rem == 0) begin
      m_dout = '0;
    end
    m_dv  = rd;
    m_lfd = l;
  endtask

  task automatic compare_all();
    check("data_out",    data_out,    m_dout);
    check("data_valid",  data_valid,  m_dv);
    check("pkt_done",    pkt_done,    m_done);
    check("empty",       empty,       q.size() == 0);
    check("full",        full,        q.size() == DEPTH);
    check("almost_full", almost_full, q.size() >= AF);
    check("fill_level",  fill_level,  q.size());
    check("pkts_stored", pkts_stored, model_pkts());
  endtask

  task automatic cycle(input bit w, input bit r, input bit l, input bit s, input logic [DW-1:0] d);
    @(negedge clock);
    write_enb = w; read_enb = r; lfd_state = l; soft_reset = s; data_in = d;
    @(posedge clock);
    model_step(w, r, l, s, d);
    #1;
    compare_all();
  endtask

  // Async reset asserted between clock edges; outputs must clear before the next edge.
  task automatic pulse_reset();
    @(negedge clock);
    #2;
    write_enb = 0; read_enb = 0; lfd_state = 0; soft_reset = 0; data_in = '0;
    reset = 1;
    #1;
    model_clear();
    check("rst_data_out",   data_out,    0);
    check("rst_data_valid", data_valid,  0);
    check("rst_empty",      empty,       1);
    check("rst_full",       full,        0);
    check("rst_fill",       fill_level,  0);
    check("rst_pkts",       pkts_stored, 0);
    check("rst_pkt_done",   pkt_done,    0);
    @(posedge clock);
    @(negedge clock);
    reset = 0;
  endtask

  initial begin
    int dv_cnt, done_cnt, af_first;
    logic [DW-1:0] pay [4];

    pulse_reset();

    // 1: one packet, header len 3, read continuously.
    pay = '{8'h11, 8'h22, 8'h33, 8'h5A};
    dv_cnt = 0; done_cnt = 0;
    cycle(0, 0, 1, 0, '0);
    cycle(1, 1, 0, 0, 8'h0C);
    check("t1_pkts_after_hdr", pkts_stored, 1);
    for (int i = 0; i < 4; i++) begin
      cycle(1, 1, 0, 0, pay[i]);
      dv_cnt += int'(data_valid);
      done_cnt += int'(pkt_done);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(0, 1, 0, 0, '0);
      dv_cnt += int'(data_valid);
      done_cnt += int'(pkt_done);
    end
    check("t1_valid_cycles", dv_cnt, 5);
    check("t1_done_pulses",  done_cnt, 1);
    check("t1_pkts_end",     pkts_stored, 0);
    check("t1_dout_idle",    data_out, 0);

    // 2: overfill, then drain in order.
    pulse_reset();
    af_first = -1;
    for (int i = 0; i < 17; i++) begin
      cycle(1, 0, 0, 0, DW'(8'h40 + i));
      if (almost_full && af_first < 0) af_first = i + 1;
    end
    check("t2_full",     full, 1);
    check("t2_fill",     fill_level, 16);
    check("t2_af_first", af_first, AF);
    for (int i = 0; i < 16; i++) begin
      cycle(0, 1, 0, 0, '0);
      check("t2_order", data_out, 8'h40 + i);
    end
    check("t2_empty", empty, 1);

    // 3: simultaneous write+read at full and at empty.
    pulse_reset();
    for (int i = 0; i < 16; i++) cycle(1, 0, 0, 0, DW'($urandom));
    cycle(1, 1, 0, 0, 8'hEE);
    check("t3_fill_at_full", fill_level, 15);
    for (int i = 0; i < 15; i++) cycle(0, 1, 0, 0, '0);
    cycle(1, 1, 0, 0, 8'h77);
    check("t3_fill_at_empty",  fill_level, 1);
    check("t3_valid_at_empty", data_valid, 0);
    cycle(0, 1, 0, 0, '0);
    check("t3_no_bypass_word", data_out, 8'h77);

    // 4: interleaved traffic across pointer wrap.
    for (int i = 0; i < 80; i++)
      cycle(($urandom % 4) != 0, ($urandom % 4) != 0, 0, 0, DW'($urandom));

    // 5: soft_reset mid-packet with a simultaneous write.
    pulse_reset();
    cycle(0, 0, 1, 0, '0);
    cycle(1, 0, 0, 0, 8'h28);
    for (int i = 0; i < 7; i++) cycle(1, 0, 0, 0, DW'(i + 1));
    cycle(0, 1, 0, 0, '0);
    check("t5_fill_before", fill_level, 7);
    cycle(1, 0, 0, 1, 8'hAA);
    check("t5_fill",  fill_level, 0);
    check("t5_empty", empty, 1);
    check("t5_dout",  data_out, 0);
    cycle(0, 1, 0, 0, '0);
    check("t5_write_dropped", data_valid, 0);

    // 6: async reset mid-read, then a clean packet.
    cycle(0, 0, 1, 0, '0);
    cycle(1, 0, 0, 0, 8'h10);
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0, DW'(8'hC0 + i));
    cycle(0, 1, 0, 0, '0);
    cycle(0, 1, 0, 0, '0);
    pulse_reset();
    cycle(0, 0, 1, 0, '0);
    cycle(1, 1, 0, 0, 8'h04);
    cycle(1, 1, 0, 0, 8'h99);
    cycle(1, 1, 0, 0, 8'h66);
    cycle(0, 1, 0, 0, '0);
    cycle(0, 1, 0, 0, '0);

    // Random traffic with packet tags and occasional flushes.
    for (int i = 0; i < 600; i++)
      cycle(($urandom % 3) != 0, ($urandom % 3) != 0, ($urandom % 6) == 0,
            ($urandom % 60) == 0, DW'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
